// File: rtl/segment_window_stats.sv
// Windowed pixel pass-through for one horizontal band, with per-window dark-pixel counts
// accumulated over a frame and snapshotted at the following frame start.
module segment_window_stats #(
   parameter int NUM_SEG   = 6,
   parameter int X0        = 51,
   parameter int SEG_W     = 74,
   parameter int SEG_PITCH = 90,
   parameter int Y0        = 151,
   parameter int Y1        = 299,
   parameter int DARK_TH   = 24,
   parameter int CNT_W     = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   input  logic             en,
   input  logic [9:0]       hcnt,
   input  logic [9:0]       vcnt,
   input  logic [11:0]      pixelIn,
   output logic [11:0]      pixelOut,
   output logic             in_seg,
   output logic [2:0]       seg_idx,
   output logic             res_valid,
   input  logic [2:0]       seg_sel,
   output logic [CNT_W-1:0] seg_count
);

   localparam int LAST_COL = X0 + (NUM_SEG - 1) * SEG_PITCH + SEG_W - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (NUM_SEG < 1 || NUM_SEG > 8 || SEG_W < 1 || SEG_PITCH < SEG_W || X0 < 0 ||
       LAST_COL > 1023 || Y0 < 0 || Y1 < Y0 || Y1 > 1023 || CNT_W < 1) begin : gCfgErr
      $error("segment_window_stats: invalid window configuration");
   end

   // state | meaning
   // IDLE  | statistics off, accumulators held at zero
   // ARMED | waiting for the first frame start; partial frame is discarded
   // ACCUM | counting dark pixels, publishing a snapshot at every frame start
   typedef enum logic [1:0] {IDLE, ARMED, ACCUM} state_t;

   state_t           state;
   logic [CNT_W-1:0] acc  [NUM_SEG];
   logic [CNT_W-1:0] snap [NUM_SEG];

   logic       inBand;
   logic       hit;
   logic [2:0] hitIdx;
   logic [5:0] lumSum;
   logic       dark;
   logic       countHit;
   logic       fs;

   // Window bounds are elaboration constants; the loop unrolls into plain comparators.
   always_comb begin
      inBand = (vcnt >= 10'(Y0)) && (vcnt <= 10'(Y1));
      hit    = 1'b0;
      hitIdx = '0;
      for (int k = 0; k < NUM_SEG; k++) begin
         if (inBand && (hcnt >= 10'(X0 + k * SEG_PITCH)) &&
             (hcnt <= 10'(X0 + k * SEG_PITCH + SEG_W - 1))) begin
            hit    = 1'b1;
            hitIdx = 3'(k);
         end
      end
      lumSum   = 6'(pixelIn[11:8]) + 6'(pixelIn[7:4]) + 6'(pixelIn[3:0]);
      dark     = lumSum < 6'(DARK_TH);
      countHit = hit && dark;
      fs       = pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pixelOut  <= '0;
         in_seg    <= 1'b0;
         seg_idx   <= '0;
         res_valid <= 1'b0;
         for (int k = 0; k < NUM_SEG; k++) begin
            acc[k]  <= '0;
            snap[k] <= '0;
         end
      end else begin
         res_valid <= 1'b0;

         if (pix_en) begin
            pixelOut <= hit ? pixelIn : 12'h000;
            in_seg   <= hit;
            seg_idx  <= hitIdx;
         end

         // Dropping en does not wait for a pixel beat.
         if (!en) begin
            state <= IDLE;
            for (int k = 0; k < NUM_SEG; k++) acc[k] <= '0;
         end else if (pix_en) begin
            unique case (state)
               IDLE: state <= ARMED;
               ARMED: begin
                  if (fs) begin
                     state <= ACCUM;
                     for (int k = 0; k < NUM_SEG; k++)
                        acc[k] <= (countHit && hitIdx == 3'(k)) ? CNT_W'(1) : '0;
                  end
               end
               ACCUM: begin
                  if (fs) begin
                     res_valid <= 1'b1;
                     // The frame-start pixel belongs to the new frame.
                     for (int k = 0; k < NUM_SEG; k++) begin
                        snap[k] <= acc[k];
                        acc[k]  <= (countHit && hitIdx == 3'(k)) ? CNT_W'(1) : '0;
                     end
                  end else if (countHit) begin
                     for (int k = 0; k < NUM_SEG; k++)
                        if (hitIdx == 3'(k) && acc[k] != CNT_MAX) acc[k] <= acc[k] + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      seg_count = '0;
      for (int k = 0; k < NUM_SEG; k++)
         if (seg_sel == 3'(k)) seg_count = snap[k];
   end

endmodule

// File: tb/tb_segment_window_stats.sv
`timescale 1ns/1ps
// Scoreboarded bench for segment_window_stats: directed pixel-path vectors and frame
// statistics on a default instance and a narrow-counter (saturating) instance.
module tb_segment_window_stats;
   logic        clk = 1'b0;
   logic        rst, pix_en, en;
   logic [9:0]  hcnt, vcnt;
   logic [11:0] pixelIn;
   logic [2:0]  seg_sel;
   logic [11:0] pixelOut, pixelOut10;
   logic        in_seg, in_seg10, res_valid, res_valid10;
   logic [2:0]  seg_idx, seg_idx10;
   logic [13:0] seg_count;
   logic [9:0]  seg_count10;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic [11:0] pix;
      logic        ins;
      logic [2:0]  idx;
   } pixExp_t;

   pixExp_t pixQ[$];
   pixExp_t lastExp;
   pixExp_t monExp;
   int      resQ[$];
   int      f1a[8];
   int      f1b[8];
   int      f3[8];

   always #10 clk = ~clk;

   segment_window_stats dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .en(en), .hcnt(hcnt), .vcnt(vcnt),
      .pixelIn(pixelIn), .pixelOut(pixelOut), .in_seg(in_seg), .seg_idx(seg_idx),
      .res_valid(res_valid), .seg_sel(seg_sel), .seg_count(seg_count)
   );

   segment_window_stats #(.CNT_W(10)) dut10 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .en(en), .hcnt(hcnt), .vcnt(vcnt),
      .pixelIn(pixelIn), .pixelOut(pixelOut10), .in_seg(in_seg10), .seg_idx(seg_idx10),
      .res_valid(res_valid10), .seg_sel(seg_sel), .seg_count(seg_count10)
   );

   task automatic check(input string name, input longint act, input longint exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int h, input int v, input logic [11:0] p);
      @(negedge clk);
      hcnt    = 10'(h);
      vcnt    = 10'(v);
      pixelIn = p;
      pix_en  = 1'b1;
   endtask

   task automatic px(input int h, input int v, input logic [11:0] p,
                     input logic [11:0] ep, input logic ei, input int ex);
      pixExp_t e;
      e.pix = ep;
      e.ins = ei;
      e.idx = 3'(ex);
      drive(h, v, p);
      pixQ.push_back(e);
      lastExp = e;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      pix_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic readSnap(input int sel, input int e14, input int e10);
      seg_sel = 3'(sel);
      #1;
      check($sformatf("snap_sel%0d", sel), seg_count, e14);
      check($sformatf("snap10_sel%0d", sel), seg_count10, e10);
   endtask

   // Pixel monitor: one expectation per qualified beat, compared after the edge.
   always @(posedge clk) begin
      if (pix_en && pixQ.size() > 0) begin
         monExp = pixQ.pop_front();
         #1;
         check("pixelOut", pixelOut, monExp.pix);
         check("in_seg", in_seg, monExp.ins);
         check("seg_idx", seg_idx, monExp.idx);
         check("pixelOut10", pixelOut10, monExp.pix);
      end
   end

   // Result monitor: every res_valid pulse must match a queued snapshot set.
   always @(posedge clk) begin
      #1;
      if (res_valid) begin
         if (resQ.size() < 16) begin
            check("res_valid_unexpected", res_valid, 0);
         end else begin
            check("res_valid10", res_valid10, 1);
            for (int k = 0; k < 8; k++) begin
               seg_sel = 3'(k);
               #1;
               check($sformatf("seg_count[%0d]", k), seg_count, resQ[k]);
               check($sformatf("seg_count10[%0d]", k), seg_count10, resQ[8 + k]);
            end
            repeat (16) void'(resQ.pop_front());
         end
      end
   end

   initial begin
      f1a = '{11026, 11026, 11026, 11026, 11026, 11026, 0, 0};
      f1b = '{1023, 1023, 1023, 1023, 1023, 1023, 0, 0};
      f3  = '{2, 2, 3, 4, 5, 6, 0, 0};

      rst = 1'b1; en = 1'b0; pix_en = 1'b0;
      hcnt = '0; vcnt = '0; pixelIn = '0; seg_sel = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_pixelOut", pixelOut, 0);
      check("rst_in_seg", in_seg, 0);
      check("rst_seg_idx", seg_idx, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_seg_count", seg_count, 0);

      // Basic pass-through, band edges, window edges
      px(60, 200, 12'hFFF, 12'hFFF, 1'b1, 0);
      px(60, 150, 12'hABC, 12'h000, 1'b0, 0);
      px(60, 151, 12'hABC, 12'hABC, 1'b1, 0);
      px(60, 299, 12'hABC, 12'hABC, 1'b1, 0);
      px(60, 300, 12'hABC, 12'h000, 1'b0, 0);
      px(140, 200, 12'h5A5, 12'h000, 1'b0, 0);
      px(141, 200, 12'h5A5, 12'h5A5, 1'b1, 1);
      px(214, 200, 12'h5A5, 12'h5A5, 1'b1, 1);
      px(215, 200, 12'h5A5, 12'h000, 1'b0, 0);
      px(130, 200, 12'h5A5, 12'h000, 1'b0, 0);
      px(50, 200, 12'h123, 12'h000, 1'b0, 0);
      px(51, 200, 12'h123, 12'h123, 1'b1, 0);
      px(574, 200, 12'h5A5, 12'h5A5, 1'b1, 5);
      px(575, 200, 12'h5A5, 12'h000, 1'b0, 0);
      idle(2);

      // Statistics: discarded partial frame, then one full all-dark frame
      @(negedge clk);
      en = 1'b1;
      drive(5, 5, 12'h000);
      for (int h = 51; h < 61; h++) drive(h, 200, 12'h000);
      drive(0, 0, 12'h000);
      for (int v = 151; v <= 299; v++)
         for (int k = 0; k < 6; k++)
            for (int h = 51 + k * 90; h < 51 + k * 90 + 74; h++)
               drive(h, v, 12'h000);
      drive(130, 200, 12'h000);
      drive(60, 150, 12'h000);
      drive(60, 300, 12'h000);
      drive(575, 299, 12'h000);
      drive(50, 151, 12'h000);
      for (int k = 0; k < 8; k++) resQ.push_back(f1a[k]);
      for (int k = 0; k < 8; k++) resQ.push_back(f1b[k]);
      drive(0, 0, 12'h000);

      // Mid-frame disable: partial frame dropped, snapshot retained
      for (int h = 60; h < 65; h++) drive(h, 200, 12'h000);
      @(negedge clk);
      en = 1'b0;
      pix_en = 1'b0;
      repeat (2) @(negedge clk);
      readSnap(0, 11026, 1023);
      readSnap(5, 11026, 1023);
      readSnap(6, 0, 0);
      readSnap(7, 0, 0);
      @(negedge clk);
      en = 1'b1;
      drive(5, 5, 12'h000);
      for (int h = 60; h < 65; h++) drive(h, 200, 12'h000);
      drive(0, 0, 12'h000);

      // Small frame with threshold edges and a pixel-clock stall
      px(51, 200, 12'h000, 12'h000, 1'b1, 0);
      px(52, 200, 12'h887, 12'h887, 1'b1, 0);
      px(141, 200, 12'h000, 12'h000, 1'b1, 1);
      px(142, 200, 12'h888, 12'h888, 1'b1, 1);
      px(214, 200, 12'h000, 12'h000, 1'b1, 1);
      for (int h = 231; h < 234; h++) px(h, 200, 12'h000, 12'h000, 1'b1, 2);
      px(234, 200, 12'hFFF, 12'hFFF, 1'b1, 2);
      @(negedge clk);
      pix_en = 1'b0;
      hcnt = 10'd321;
      pixelIn = 12'h000;
      repeat (3) begin
         @(negedge clk);
         check("hold_pixelOut", pixelOut, lastExp.pix);
         check("hold_in_seg", in_seg, lastExp.ins);
         check("hold_seg_idx", seg_idx, lastExp.idx);
      end
      for (int h = 321; h < 325; h++) px(h, 200, 12'h000, 12'h000, 1'b1, 3);
      for (int h = 411; h < 416; h++) px(h, 200, 12'h000, 12'h000, 1'b1, 4);
      for (int h = 501; h < 506; h++) px(h, 200, 12'h000, 12'h000, 1'b1, 5);
      px(574, 200, 12'h000, 12'h000, 1'b1, 5);
      px(130, 200, 12'h000, 12'h000, 1'b0, 0);
      px(575, 200, 12'h000, 12'h000, 1'b0, 0);
      px(60, 150, 12'h000, 12'h000, 1'b0, 0);
      px(60, 300, 12'h000, 12'h000, 1'b0, 0);
      for (int k = 0; k < 8; k++) resQ.push_back(f3[k]);
      for (int k = 0; k < 8; k++) resQ.push_back(f3[k]);
      px(0, 0, 12'h000, 12'h000, 1'b0, 0);
      px(60, 200, 12'hABC, 12'hABC, 1'b1, 0);
      idle(4);

      check("res_pending", resQ.size(), 0);
      check("pix_pending", pixQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
